// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory between the fetch port and the data port
module mem_port_arbiter #(
    parameter int N          = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    input  logic         if_flush,
    output logic [N-1:0] if_rdata,
    output logic         if_done,
    input  logic         dm_rd,
    input  logic         dm_wr,
    input  logic [N-1:0] dm_addr,
    input  logic [N-1:0] dm_wdata,
    output logic [N-1:0] dm_rdata,
    output logic         dm_done,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         mem_rd,
    output logic         mem_wr,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_done,
    input  logic         mem_stall,
    input  logic         mem_err,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t       state;
    state_t       state_nx;

    logic         port_data;
    logic         op_rd;
    logic         op_wr;
    logic [N-1:0] addr_q;
    logic [N-1:0] wdata_q;
    logic         err_q;
    logic         cancel_q;
    logic [3:0]   starve_cnt;
    logic [N-1:0] if_rdata_q;
    logic [N-1:0] dm_rdata_q;

    logic         fetch_ok;
    logic         data_req;
    logic         illegal;
    logic         starved;
    logic         grant_data;
    logic         grant_fetch;
    logic         in_access;
    logic         unused_stall;

    assign fetch_ok     = if_req & ~if_flush;
    assign data_req     = dm_rd | dm_wr;
    assign illegal      = dm_rd & dm_wr;
    assign starved      = (starve_cnt == STARVE_LIM);
    assign in_access    = (state == ISSUE) || (state == WAIT);
    assign unused_stall = mem_stall;

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        if_done     = 1'b0;
        dm_done     = 1'b0;
        err         = 1'b0;
        busy        = (state != IDLE);
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        case (state)
            IDLE: begin
                // Data has priority unless fetch has waited out its starvation budget.
                if (data_req && !(starved && fetch_ok)) begin
                    grant_data = 1'b1;
                    state_nx   = illegal ? RESP : ISSUE;
                end else if (fetch_ok) begin
                    grant_fetch = 1'b1;
                    state_nx    = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd   = op_rd;
                mem_wr   = op_wr;
                state_nx = mem_done ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_done) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
                if (port_data) begin
                    dm_done = 1'b1;
                    err     = err_q;
                end else if (!cancel_q && !if_flush) begin
                    if_done = 1'b1;
                    err     = err_q;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_data  <= 1'b0;
            op_rd      <= 1'b0;
            op_wr      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            cancel_q   <= 1'b0;
            starve_cnt <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (grant_data) begin
                port_data <= 1'b1;
                op_rd     <= dm_rd & ~dm_wr;
                op_wr     <= dm_wr & ~dm_rd;
                addr_q    <= dm_addr;
                wdata_q   <= dm_wdata;
                err_q     <= illegal;
                cancel_q  <= 1'b0;
                if (fetch_ok) begin
                    if (!starved) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end else begin
                    starve_cnt <= '0;
                end
            end else if (grant_fetch) begin
                port_data  <= 1'b0;
                op_rd      <= 1'b1;
                op_wr      <= 1'b0;
                addr_q     <= if_addr;
                wdata_q    <= '0;
                err_q      <= 1'b0;
                cancel_q   <= 1'b0;
                starve_cnt <= '0;
            end

            if (in_access) begin
                if (mem_err) begin
                    err_q <= 1'b1;
                end
                // A flushed fetch still runs to completion; only its done pulse is dropped.
                if (if_flush && !port_data) begin
                    cancel_q <= 1'b1;
                end
                if (mem_done && op_rd) begin
                    if (port_data) begin
                        dm_rdata_q <= mem_rdata;
                    end else begin
                        if_rdata_q <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        dm_rd = 1'b0;
    logic        dm_wr = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata = '0;
    logic        mem_done = 1'b0;
    logic        mem_stall = 1'b0;
    logic        mem_err = 1'b0;
    logic        busy;
    logic        err;

    mem_port_arbiter #(.N(16), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_done(if_done),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_err(mem_err),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          is_data;
        bit          chk_data;
        bit          err;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];

    task automatic push(input bit d, input bit cd, input bit e, input logic [15:0] r);
        exp_t x;
        x.is_data  = d;
        x.chk_data = cd;
        x.err      = e;
        x.rdata    = r;
        sb.push_back(x);
    endtask

    function automatic logic [15:0] rd_fn(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    // Memory model: answers a strobe after lat further cycles (lat=0 -> same cycle).
    int          lat = 0;
    bit          err_inject = 0;
    bit          pending = 0;
    int          cnt = 0;
    logic [15:0] paddr, pwdata;
    bit          pwr;
    int          mem_done_cnt = 0;
    logic [15:0] mem_arr [logic [15:0]];

    always @(negedge clk) begin
        mem_done = 1'b0;
        mem_err  = 1'b0;
        if (!rst) begin
            pending = 0;
        end else begin
            if (mem_rd || mem_wr) begin
                pending = 1;
                cnt     = 0;
                paddr   = mem_addr;
                pwdata  = mem_wdata;
                pwr     = mem_wr;
            end
            if (pending) begin
                if (cnt >= lat) begin
                    mem_done = 1'b1;
                    mem_err  = err_inject;
                    pending  = 0;
                    mem_done_cnt++;
                    if (pwr) mem_arr[paddr] = pwdata;
                    else     mem_rdata = rd_fn(paddr);
                end else begin
                    cnt++;
                end
            end
        end
        mem_stall = pending;
    end

    // Completion monitor, sampled after stimulus settles.
    always begin
        @(posedge clk);
        #2;
        if (if_done || dm_done) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_port", {if_done, dm_done}, e.is_data ? 2'b01 : 2'b10);
                check("sb_err", err, e.err);
                if (e.chk_data) check("sb_rdata", e.is_data ? dm_rdata : if_rdata, e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit data, input string tag);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (data ? dm_done : if_done) seen = 1;
        end
        check(tag, seen, 1);
    endtask

    initial begin
        bit   early_if;
        bit   seen;
        int   ndone;
        int   base;
        bit   pat [10];

        // Reset state
        tick();
        tick();
        check("rst_outputs", {busy, mem_rd, mem_wr, if_done, dm_done, err}, 6'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_rdata", {if_rdata, dm_rdata}, 32'h0);
        rst = 1'b1;
        tick();

        // Fetch hit: strobe in cycle 1 only, done in cycle 2
        lat = 0;
        if_addr = 16'h0010;
        if_req = 1'b1;
        push(0, 1, 0, 16'h1234);
        tick();
        check("t1_mem_rd_c1", mem_rd, 1);
        check("t1_mem_addr", mem_addr, 16'h0010);
        check("t1_no_done_c1", if_done, 0);
        tick();
        check("t1_mem_rd_c2", mem_rd, 0);
        check("t1_if_done_c2", if_done, 1);
        check("t1_if_rdata", if_rdata, 16'h1234);
        if_req = 1'b0;
        tick();
        check("t1_idle", busy, 0);

        // Simultaneous fetch and write: data first
        lat = 3;
        push(1, 0, 0, 16'h0);
        push(0, 1, 0, rd_fn(16'h0020));
        if_addr = 16'h0020;
        if_req = 1'b1;
        dm_addr = 16'h0040;
        dm_wdata = 16'hBEEF;
        dm_wr = 1'b1;
        tick();
        check("t2_wr_strobe", {mem_wr, mem_rd}, 2'b10);
        check("t2_wr_addr", mem_addr, 16'h0040);
        check("t2_wr_data", mem_wdata, 16'hBEEF);
        early_if = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (if_done) early_if = 1;
            if (dm_done) seen = 1;
        end
        check("t2_dm_done", seen, 1);
        check("t2_no_early_if", early_if, 0);
        dm_wr = 1'b0;
        wait_done(0, "t2_if_done");
        if_req = 1'b0;
        check("t2_mem_written", mem_arr.exists(16'h0040) ? mem_arr[16'h0040] : 16'h0, 16'hBEEF);
        tick();

        // Starvation guard: D,D,D,D,F repeating
        lat = 0;
        pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 10; i++)
            push(pat[i], 1, 0, pat[i] ? rd_fn(16'h0080) : rd_fn(16'h0030));
        dm_addr = 16'h0080;
        if_addr = 16'h0030;
        dm_rd = 1'b1;
        if_req = 1'b1;
        ndone = 0;
        for (int i = 0; i < 100 && ndone < 10; i++) begin
            tick();
            if (dm_done || if_done) ndone++;
        end
        check("t3_completions", ndone, 10);
        dm_rd = 1'b0;
        if_req = 1'b0;
        tick();
        tick();

        // Flush during WAIT of a fetch
        lat = 3;
        base = mem_done_cnt;
        if_addr = 16'h0050;
        if_req = 1'b1;
        tick();
        tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        if_req = 1'b0;
        seen = 0;
        early_if = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (if_done) early_if = 1;
            if (!busy) seen = 1;
        end
        check("t4_busy_clear", seen, 1);
        check("t4_no_if_done", early_if, 0);
        check("t4_mem_completed", mem_done_cnt - base, 1);
        lat = 1;
        dm_addr = 16'h0090;
        dm_rd = 1'b1;
        push(1, 1, 0, rd_fn(16'h0090));
        wait_done(1, "t4_dm_done");
        dm_rd = 1'b0;
        tick();

        // Illegal rd+wr
        dm_addr = 16'h00C0;
        dm_rd = 1'b1;
        dm_wr = 1'b1;
        push(1, 0, 1, 16'h0);
        tick();
        check("t5_no_strobe", {mem_rd, mem_wr}, 2'b00);
        check("t5_done_err", {dm_done, err}, 2'b11);
        dm_rd = 1'b0;
        dm_wr = 1'b0;
        tick();

        // mem_err during WAIT
        lat = 2;
        err_inject = 1;
        dm_addr = 16'h00A0;
        dm_rd = 1'b1;
        push(1, 1, 1, rd_fn(16'h00A0));
        wait_done(1, "t5b_dm_done");
        check("t5b_err", err, 1);
        dm_rd = 1'b0;
        err_inject = 0;
        tick();
        tick();
        check("t5b_err_clear", err, 0);

        // Reset during WAIT
        lat = 5;
        dm_addr = 16'h00B0;
        dm_rd = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        dm_rd = 1'b0;
        #1;
        check("t6_rst_outputs", {busy, mem_rd, mem_wr, if_done, dm_done, err}, 6'b0);
        check("t6_rst_data", {mem_addr, dm_rdata}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        lat = 0;
        if_addr = 16'h0010;
        if_req = 1'b1;
        push(0, 1, 0, 16'h1234);
        wait_done(0, "t6_if_done");
        if_req = 1'b0;
        tick();
        tick();

        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
